// File: rtl/wash_cycle_controller.sv
// Master washing-machine sequencer: start, ready, fill, heat, wash, rinse, spin.
// Optional watchdog/fault state under WASH_CTRL_WATCHDOG_EN.
module wash_cycle_controller #(
   parameter int CYCLE_CNT_W = 8,
   parameter int WDOG_LIMIT  = 31,
   parameter int WDOG_W      = 5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   door_Closed,
   input  logic                   start_Button,
   input  logic                   sig_Full,
   input  logic                   sig_Temperature,
   input  logic                   sig_Wash_Completed,
   input  logic                   sig_Rinse_Completed,
   input  logic                   sig_Spin_Completed,
   input  logic                   fault_Clear,
   output logic [2:0]             state,
   output logic                   water_Valve,
   output logic                   heater,
   output logic                   wash_Motor,
   output logic                   spin_Motor,
   output logic                   drain_Valve,
   output logic                   door_Lock,
   output logic                   cycle_Done,
   output logic [CYCLE_CNT_W-1:0] cycles_Completed,
   output logic                   fault
);

   typedef enum logic [2:0] {
      S_START = 3'd0,
      S_READY = 3'd1,
      S_FILL  = 3'd2,
      S_HEAT  = 3'd3,
      S_WASH  = 3'd4,
      S_RINSE = 3'd5,
      S_SPIN  = 3'd6,
      S_FAULT = 3'd7
   } state_t;

   state_t                 state_q, state_d;
   logic                   done_q, done_d;
   logic [CYCLE_CNT_W-1:0] cnt_q, cnt_d;
   logic                   running;
   logic                   flag_cur;

   assign running = (state_q >= S_FILL) && (state_q <= S_SPIN);

   // Only the flag owned by the current state may advance it.
   always_comb begin
      flag_cur = 1'b0;
      case (state_q)
         S_FILL:  flag_cur = sig_Full;
         S_HEAT:  flag_cur = sig_Temperature;
         S_WASH:  flag_cur = sig_Wash_Completed;
         S_RINSE: flag_cur = sig_Rinse_Completed;
         S_SPIN:  flag_cur = sig_Spin_Completed;
         default: flag_cur = 1'b0;
      endcase
   end

`ifdef WASH_CTRL_WATCHDOG_EN
   logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
   logic unused_cfg;
   assign unused_cfg = fault_Clear ^ (WDOG_LIMIT > 0) ^ (WDOG_W > 0);
`endif

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         S_START: if (door_Closed) state_d = S_READY;
         S_READY: begin
            if (!door_Closed)      state_d = S_START;
            else if (start_Button) state_d = S_FILL;
         end
         S_FILL:  if (flag_cur) state_d = S_HEAT;
         S_HEAT:  if (flag_cur) state_d = S_WASH;
         S_WASH:  if (flag_cur) state_d = S_RINSE;
         S_RINSE: if (flag_cur) state_d = S_SPIN;
         S_SPIN: begin
            if (flag_cur) begin
               state_d = S_START;
               done_d  = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
`ifdef WASH_CTRL_WATCHDOG_EN
            if (fault_Clear) state_d = S_FAULT == state_q ? S_START : state_q;
`else
            state_d = S_START;
`endif
         end
      endcase
`ifdef WASH_CTRL_WATCHDOG_EN
      // An open door trumps everything; a flag beats an expiring watchdog.
      if (running) begin
         if (!door_Closed) begin
            state_d = S_FAULT;
            done_d  = 1'b0;
            cnt_d   = cnt_q;
         end else if (!flag_cur &&
                      wdog_q >= WDOG_W'(WDOG_LIMIT - 1)) begin
            state_d = S_FAULT;
         end
      end
      wdog_d = (running && state_d == state_q) ? wdog_q + 1'b1 : '0;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_START;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef WASH_CTRL_WATCHDOG_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) wdog_q <= '0;
      else       wdog_q <= wdog_d;
   end
   assign fault = (state_q == S_FAULT);
`else
   assign fault = 1'b0;
`endif

   assign state            = state_q;
   assign water_Valve      = (state_q == S_FILL);
   assign heater           = (state_q == S_HEAT);
   assign wash_Motor       = (state_q == S_WASH) || (state_q == S_RINSE);
   assign spin_Motor       = (state_q == S_SPIN);
   assign drain_Valve      = (state_q == S_RINSE) || (state_q == S_SPIN);
   assign door_Lock        = (state_q != S_START) && (state_q != S_READY);
   assign cycle_Done       = done_q;
   assign cycles_Completed = cnt_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Bench for wash_cycle_controller: reference model plus directed phases.
module tb_wash_cycle_controller;

   logic       clock, reset, door, start, fclr;
   logic [6:2] flg;
   logic [2:0] state;
   logic       water, heat, wmot, smot, drain, lock, done, fault;
   logic [7:0] cnt;

   int checks = 0;
   int errors = 0;

   int m_state, m_cnt, m_wd;
   bit m_done;

   wash_cycle_controller #(.CYCLE_CNT_W(8), .WDOG_LIMIT(31), .WDOG_W(5)) dut (
      .clock(clock), .reset(reset),
      .door_Closed(door), .start_Button(start),
      .sig_Full(flg[2]), .sig_Temperature(flg[3]),
      .sig_Wash_Completed(flg[4]), .sig_Rinse_Completed(flg[5]),
      .sig_Spin_Completed(flg[6]), .fault_Clear(fclr),
      .state(state), .water_Valve(water), .heater(heat),
      .wash_Motor(wmot), .spin_Motor(smot), .drain_Valve(drain),
      .door_Lock(lock), .cycle_Done(done),
      .cycles_Completed(cnt), .fault(fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Next phase of the wash program, from the rules of operation.
   function automatic int nxt(int s);
      if (s == 0) return door ? 1 : 0;
      if (s == 1) return !door ? 0 : (start ? 2 : 1);
`ifdef WASH_CTRL_WATCHDOG_EN
      if (s == 7) return fclr ? 0 : 7;
      if (!door) return 7;
      if (flg[s]) return (s + 1) % 7;
      return (m_wd + 1 >= 31) ? 7 : s;
`else
      if (s == 7) return 0;
      return flg[s] ? (s + 1) % 7 : s;
`endif
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_state <= 0;
         m_done  <= 1'b0;
         m_cnt   <= 0;
         m_wd    <= 0;
      end else begin
         m_done  <= (m_state == 6) && (nxt(m_state) == 0);
         m_cnt   <= ((m_state == 6) && (nxt(m_state) == 0) && m_cnt < 255)
                    ? m_cnt + 1 : m_cnt;
         m_wd    <= (nxt(m_state) == m_state && m_state >= 2 && m_state <= 6)
                    ? m_wd + 1 : 0;
         m_state <= nxt(m_state);
      end
   end

   always @(negedge clock) begin
      check("state", state, m_state);
      check("water_Valve", water, m_state == 2);
      check("heater", heat, m_state == 3);
      check("wash_Motor", wmot, m_state == 4 || m_state == 5);
      check("spin_Motor", smot, m_state == 6);
      check("drain_Valve", drain, m_state == 5 || m_state == 6);
      check("door_Lock", lock, m_state >= 2);
      check("fault", fault, m_state == 7);
      check("cycle_Done", done, m_done);
      check("cycles_Completed", cnt, m_cnt);
   end

   task automatic step(int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; door = 1'b0; start = 1'b0; fclr = 1'b0; flg = '0;
      step(2);
      check("rst_state", state, 0);
      check("rst_outs", {water, heat, wmot, smot, drain, lock, done, fault}, 0);
      check("rst_cnt", cnt, 0);
      reset = 1'b0;
      door  = 1'b1;
      // Full cycle, each flag raised three cycles after entry.
      step(1);
      check("t1_ready", state, 1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      check("t1_fill", state, 2);
      for (int s = 2; s <= 6; s++) begin
         step(3);
         check("t1_hold", state, s);
         flg[s] = 1'b1;
         step(1);
         flg[s] = 1'b0;
         check("t1_walk", state, (s + 1) % 7);
      end
      check("t1_done", done, 1);
      step(1);
      check("t1_done_off", done, 0);
      check("t1_count", cnt, 1);
      // Door opening beats start button in READY.
      check("t2_ready", state, 1);
      door = 1'b0; start = 1'b1;
      step(1);
      check("t2_start", state, 0);
      check("t2_water", water, 0);
      door = 1'b1; start = 1'b0;
      // Stale flags held high in WASH do nothing.
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      flg[2] = 1'b1;
      step(1);
      flg[3] = 1'b1;
      step(1);
      step(10);
      check("t3_state", state, 4);
      check("t3_wash", wmot, 1);
      check("t3_lock", lock, 1);
      flg = '0;
      flg[4] = 1'b1;
      step(1);
      flg[4] = 1'b0;
      check("t4_rinse", state, 5);
      // Asynchronous reset between edges.
      #2 reset = 1'b1;
      #1;
      check("t4_state", state, 0);
      check("t4_outs", {water, heat, wmot, smot, drain, lock, done, fault}, 0);
      check("t4_cnt", cnt, 0);
      step(1);
      reset = 1'b0;
      // Counter saturation: every input held high, 7 cycles per run.
      start = 1'b1;
      flg   = '1;
      step(255 * 7);
      check("t5_255", cnt, 255);
      step(2 * 7);
      check("t5_sat", cnt, 255);
      check("t5_state", state, 0);
      start = 1'b0;
      flg   = '0;
`ifdef WASH_CTRL_WATCHDOG_EN
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      flg[2] = 1'b1;
      step(1);
      flg[2] = 1'b0;
      check("t6_heat", state, 3);
      step(31);
      check("t6_wdog", state, 7);
      check("t6_fault", fault, 1);
      check("t6_heater", heat, 0);
      fclr = 1'b1;
      step(1);
      fclr = 1'b0;
      check("t6_clear", state, 0);
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      door  = 1'b0;
      step(1);
      check("t6_door", state, 7);
      fclr = 1'b1;
      door = 1'b1;
      step(1);
      fclr = 1'b0;
      check("t6_clear2", state, 0);
`endif
      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
